// File: rtl/hdr_cmd_scheduler.sv
// HDR command scheduler: queues CP/TOC/TID/MODE descriptors and dispatches them
// one at a time to the CCC or DDR-mode block under a watchdog.
module hdr_cmd_scheduler #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_W   = 10,
  parameter int unsigned TIMEOUT_MAX = 1000
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst_n,
  input  logic       i_sched_en,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic       i_cmd_cp,
  input  logic       i_cmd_toc,
  input  logic [3:0] i_cmd_tid,
  input  logic [2:0] i_cmd_mode,
  output logic       o_ccc_en,
  input  logic       i_ccc_done,
  output logic       o_ddrmode_en,
  input  logic       i_ddr_mode_done,
  output logic [3:0] o_tid,
  output logic       o_restart_req,
  output logic       o_exit_req,
  output logic       o_sched_done,
  output logic       o_mode_err,
  output logic       o_timeout_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;
  localparam logic [2:0]           MODE_DDR = 3'd6;
  localparam logic [TIMEOUT_W-1:0] WD_LAST  = TIMEOUT_W'(TIMEOUT_MAX - 1);

  typedef enum logic [1:0] {IDLE, RUN, TERM} state_t;

  typedef struct packed {
    logic       cp;
    logic       toc;
    logic [3:0] tid;
    logic [2:0] mode;
  } desc_t;

  desc_t                mem [DEPTH];
  desc_t                head;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 flush;
  logic                 sel_done;
  logic                 abort;
  state_t               state;
  logic                 cur_cp;
  logic                 cur_toc;
  logic [TIMEOUT_W-1:0] wdog;

  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty       = (wr_ptr == rd_ptr);
  assign o_cmd_ready = i_sched_en & ~full;
  assign push        = i_cmd_valid & o_cmd_ready;
  assign head        = mem[rd_ptr[AW-1:0]];
  assign pop         = i_sched_en & (state == IDLE) & ~empty;
  assign sel_done    = cur_cp ? i_ccc_done : i_ddr_mode_done;
  // done sampled in the same cycle as the last watchdog count takes priority
  assign abort       = (state == RUN) & ~sel_done & (wdog == WD_LAST);
  assign flush       = ~i_sched_en | abort;

  always_ff @(posedge i_sys_clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {i_cmd_cp, i_cmd_toc, i_cmd_tid, i_cmd_mode};
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state         <= IDLE;
      cur_cp        <= 1'b0;
      cur_toc       <= 1'b0;
      wdog          <= '0;
      o_ccc_en      <= 1'b0;
      o_ddrmode_en  <= 1'b0;
      o_tid         <= '0;
      o_restart_req <= 1'b0;
      o_exit_req    <= 1'b0;
      o_sched_done  <= 1'b0;
      o_mode_err    <= 1'b0;
      o_timeout_err <= 1'b0;
    end else begin
      o_restart_req <= 1'b0;
      o_exit_req    <= 1'b0;
      o_sched_done  <= 1'b0;
      o_mode_err    <= 1'b0;
      if (!i_sched_en) begin
        state         <= IDLE;
        wdog          <= '0;
        o_ccc_en      <= 1'b0;
        o_ddrmode_en  <= 1'b0;
        o_timeout_err <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (pop) begin
              cur_cp  <= head.cp;
              cur_toc <= head.toc;
              o_tid   <= head.tid;
              wdog    <= '0;
              if (head.mode != MODE_DDR) begin
                o_mode_err <= 1'b1;
              end else begin
                state        <= RUN;
                o_ccc_en     <= head.cp;
                o_ddrmode_en <= ~head.cp;
              end
            end
          end
          RUN: begin
            if (sel_done) begin
              state        <= TERM;
              o_ccc_en     <= 1'b0;
              o_ddrmode_en <= 1'b0;
            end else if (abort) begin
              // an aborted transaction always terminates with an exit
              state         <= TERM;
              cur_toc       <= 1'b1;
              o_ccc_en      <= 1'b0;
              o_ddrmode_en  <= 1'b0;
              o_timeout_err <= 1'b1;
            end else begin
              wdog <= wdog + TIMEOUT_W'(1);
            end
          end
          TERM: begin
            state <= IDLE;
            if (cur_toc) begin
              o_exit_req   <= 1'b1;
              o_sched_done <= 1'b1;
            end else begin
              o_restart_req <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hdr_cmd_scheduler.sv
// Scoreboard bench for hdr_cmd_scheduler: expected dispatches are queued at push
// time and matched against dispatches observed on the enable/mode_err outputs.
`timescale 1ns/1ps
module tb_hdr_cmd_scheduler;

  logic       i_sys_clk = 1'b0;
  logic       i_sys_rst_n = 1'b0;
  logic       i_sched_en = 1'b0;
  logic       i_cmd_valid = 1'b0;
  logic       o_cmd_ready;
  logic       i_cmd_cp = 1'b0;
  logic       i_cmd_toc = 1'b0;
  logic [3:0] i_cmd_tid = '0;
  logic [2:0] i_cmd_mode = '0;
  logic       o_ccc_en;
  logic       i_ccc_done = 1'b0;
  logic       o_ddrmode_en;
  logic       i_ddr_mode_done = 1'b0;
  logic [3:0] o_tid;
  logic       o_restart_req;
  logic       o_exit_req;
  logic       o_sched_done;
  logic       o_mode_err;
  logic       o_timeout_err;

  always #5 i_sys_clk = ~i_sys_clk;

  hdr_cmd_scheduler #(.DEPTH(4), .TIMEOUT_W(10), .TIMEOUT_MAX(1000)) dut (
    .i_sys_clk       (i_sys_clk),
    .i_sys_rst_n     (i_sys_rst_n),
    .i_sched_en      (i_sched_en),
    .i_cmd_valid     (i_cmd_valid),
    .o_cmd_ready     (o_cmd_ready),
    .i_cmd_cp        (i_cmd_cp),
    .i_cmd_toc       (i_cmd_toc),
    .i_cmd_tid       (i_cmd_tid),
    .i_cmd_mode      (i_cmd_mode),
    .o_ccc_en        (o_ccc_en),
    .i_ccc_done      (i_ccc_done),
    .o_ddrmode_en    (o_ddrmode_en),
    .i_ddr_mode_done (i_ddr_mode_done),
    .o_tid           (o_tid),
    .o_restart_req   (o_restart_req),
    .o_exit_req      (o_exit_req),
    .o_sched_done    (o_sched_done),
    .o_mode_err      (o_mode_err),
    .o_timeout_err   (o_timeout_err)
  );

  typedef struct {
    logic       cp;
    logic       toc;
    logic [3:0] tid;
    logic       ok;
  } exp_t;

  typedef struct {
    logic       ccc;
    logic       ddr;
    logic       merr;
    logic [3:0] tid;
    int         cyc;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   push_cyc = 0;
  logic en_d = 1'b0;

  always @(posedge i_sys_clk) begin
    cyc  <= cyc + 1;
    en_d <= o_ccc_en | o_ddrmode_en;
  end

  // Dispatch = rising enable or a mode-error drop; also watch enable exclusivity.
  always @(negedge i_sys_clk) begin
    if (i_sys_rst_n) begin
      if (((o_ccc_en | o_ddrmode_en) && !en_d) || o_mode_err)
        obs_q.push_back('{o_ccc_en, o_ddrmode_en, o_mode_err, o_tid, cyc});
      n_cmp++;
      if (o_ccc_en && o_ddrmode_en) begin
        n_bad++;
        $display("FAIL one_hot: ccc_en=%b ddrmode_en=%b, required at most one high", o_ccc_en, o_ddrmode_en);
      end
    end
  end

  task automatic tick();
    @(posedge i_sys_clk);
    #1;
  endtask

  task automatic push_cmd(input logic cp, input logic toc, input logic [3:0] tid, input logic [2:0] mode);
    int n = 0;
    i_cmd_cp = cp; i_cmd_toc = toc; i_cmd_tid = tid; i_cmd_mode = mode;
    i_cmd_valid = 1'b1;
    while (!o_cmd_ready && n < 50) begin tick(); n++; end
    n_cmp++;
    if (!o_cmd_ready) begin
      n_bad++;
      $display("FAIL push_ready: o_cmd_ready=%b after %0d cycles, required 1", o_cmd_ready, n);
    end else begin
      tick();
      push_cyc = cyc;
      exp_q.push_back('{cp, toc, tid, mode == 3'd6});
    end
    i_cmd_valid = 1'b0;
  endtask

  task automatic get_obs(output obs_t o, output bit ok);
    int n = 0;
    while (obs_q.size() == 0 && n < 40) begin tick(); n++; end
    ok = (obs_q.size() != 0);
    if (ok) o = obs_q.pop_front();
    else    o = '{1'b0, 1'b0, 1'b0, 4'd0, 0};
  endtask

  task automatic drive_done(input logic cp);
    if (cp) i_ccc_done = 1'b1; else i_ddr_mode_done = 1'b1;
    tick();
    i_ccc_done = 1'b0; i_ddr_mode_done = 1'b0;
  endtask

  task automatic test_reset();
    i_sys_rst_n = 1'b0; i_sched_en = 1'b0;
    #12;
    n_cmp++;
    if ({o_cmd_ready, o_ccc_en, o_ddrmode_en, o_tid, o_restart_req, o_exit_req,
         o_sched_done, o_mode_err, o_timeout_err} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_outputs: got ready=%b ccc=%b ddr=%b tid=%0d rs=%b ex=%b dn=%b me=%b to=%b, required all 0",
               o_cmd_ready, o_ccc_en, o_ddrmode_en, o_tid, o_restart_req, o_exit_req, o_sched_done, o_mode_err, o_timeout_err);
    end
    tick();
    i_sys_rst_n = 1'b1; i_sched_en = 1'b1;
    tick();
    n_cmp++;
    if (o_cmd_ready !== 1'b1 || {o_ccc_en, o_ddrmode_en, o_tid} !== 6'd0) begin
      n_bad++;
      $display("FAIL post_reset: got ready=%b ccc=%b ddr=%b tid=%0d, required ready=1 rest 0", o_cmd_ready, o_ccc_en, o_ddrmode_en, o_tid);
    end
  endtask

  task automatic test_single_ccc();
    obs_t o; exp_t e; bit ok; int k;
    push_cmd(1'b1, 1'b1, 4'd5, 3'd6);
    k = push_cyc;
    get_obs(o, ok); e = exp_q.pop_front();
    n_cmp++;
    if (!ok || o.tid !== e.tid || o.ccc !== (e.ok & e.cp) || o.ddr !== (e.ok & ~e.cp) || o.merr !== ~e.ok || o.cyc != k + 1) begin
      n_bad++;
      $display("FAIL single_dispatch: got ok=%0b ccc=%b ddr=%b merr=%b tid=%0d cyc=%0d, required ccc=%b ddr=%b merr=%b tid=%0d cyc=%0d",
               ok, o.ccc, o.ddr, o.merr, o.tid, o.cyc, e.ok & e.cp, e.ok & ~e.cp, ~e.ok, e.tid, k + 1);
    end
    tick(); tick();
    n_cmp++;
    if (o_ccc_en !== 1'b1 || o_ddrmode_en !== 1'b0) begin
      n_bad++;
      $display("FAIL single_hold: got ccc=%b ddr=%b, required ccc=1 ddr=0", o_ccc_en, o_ddrmode_en);
    end
    drive_done(1'b1);
    n_cmp++;
    if (o_ccc_en !== 1'b0 || {o_restart_req, o_exit_req, o_sched_done} !== 3'b000) begin
      n_bad++;
      $display("FAIL single_done_edge: got ccc=%b pulses=%b, required ccc=0 pulses=000", o_ccc_en, {o_restart_req, o_exit_req, o_sched_done});
    end
    tick();
    n_cmp++;
    if ({o_restart_req, o_exit_req, o_sched_done} !== 3'b011) begin
      n_bad++;
      $display("FAIL single_exit_pulse: got rs/ex/dn=%b, required 011", {o_restart_req, o_exit_req, o_sched_done});
    end
    tick();
    n_cmp++;
    if ({o_restart_req, o_exit_req, o_sched_done} !== 3'b000) begin
      n_bad++;
      $display("FAIL single_pulse_width: got rs/ex/dn=%b, required 000", {o_restart_req, o_exit_req, o_sched_done});
    end
  endtask

  task automatic test_restart_then_exit();
    obs_t o; exp_t e; bit ok; int m;
    push_cmd(1'b0, 1'b0, 4'd1, 3'd6);
    push_cmd(1'b1, 1'b1, 4'd2, 3'd6);
    get_obs(o, ok); e = exp_q.pop_front();
    n_cmp++;
    if (!ok || o.tid !== e.tid || o.ccc !== (e.ok & e.cp) || o.ddr !== (e.ok & ~e.cp) || o.merr !== ~e.ok) begin
      n_bad++;
      $display("FAIL rt_dispatch1: got ok=%0b ccc=%b ddr=%b merr=%b tid=%0d, required ccc=%b ddr=%b tid=%0d",
               ok, o.ccc, o.ddr, o.merr, o.tid, e.ok & e.cp, e.ok & ~e.cp, e.tid);
    end
    drive_done(1'b1);
    n_cmp++;
    if (o_ddrmode_en !== 1'b1 || o_ccc_en !== 1'b0) begin
      n_bad++;
      $display("FAIL rt_ignore_ccc_done: got ccc=%b ddr=%b, required ccc=0 ddr=1", o_ccc_en, o_ddrmode_en);
    end
    drive_done(1'b0);
    m = cyc;
    tick();
    n_cmp++;
    if ({o_restart_req, o_exit_req, o_sched_done} !== 3'b100 || o_ddrmode_en !== 1'b0) begin
      n_bad++;
      $display("FAIL rt_restart_pulse: got rs/ex/dn=%b ddr=%b, required 100 ddr=0", {o_restart_req, o_exit_req, o_sched_done}, o_ddrmode_en);
    end
    get_obs(o, ok); e = exp_q.pop_front();
    n_cmp++;
    if (!ok || o.tid !== e.tid || o.ccc !== (e.ok & e.cp) || o.ddr !== (e.ok & ~e.cp) || o.merr !== ~e.ok || o.cyc != m + 2) begin
      n_bad++;
      $display("FAIL rt_dispatch2: got ok=%0b ccc=%b ddr=%b merr=%b tid=%0d cyc=%0d, required ccc=%b ddr=%b tid=%0d cyc=%0d",
               ok, o.ccc, o.ddr, o.merr, o.tid, o.cyc, e.ok & e.cp, e.ok & ~e.cp, e.tid, m + 2);
    end
    drive_done(1'b1);
    tick();
    n_cmp++;
    if ({o_restart_req, o_exit_req, o_sched_done} !== 3'b011) begin
      n_bad++;
      $display("FAIL rt_exit_pulse: got rs/ex/dn=%b, required 011", {o_restart_req, o_exit_req, o_sched_done});
    end
    tick(); tick();
  endtask

  task automatic test_fifo_full();
    obs_t o; exp_t e; bit ok; int n;
    push_cmd(1'b0, 1'b1, 4'd3, 3'd6);
    get_obs(o, ok); e = exp_q.pop_front();
    n_cmp++;
    if (!ok || o.tid !== e.tid || o.ddr !== 1'b1 || o.ccc !== 1'b0) begin
      n_bad++;
      $display("FAIL full_first: got ok=%0b ccc=%b ddr=%b tid=%0d, required ddr=1 tid=%0d", ok, o.ccc, o.ddr, o.tid, e.tid);
    end
    push_cmd(1'b1, 1'b0, 4'd4, 3'd6);
    push_cmd(1'b0, 1'b0, 4'd5, 3'd6);
    push_cmd(1'b1, 1'b1, 4'd6, 3'd6);
    push_cmd(1'b0, 1'b1, 4'd7, 3'd6);
    n_cmp++;
    if (o_cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL full_ready: o_cmd_ready=%b after 4 pushes, required 0", o_cmd_ready);
    end
    i_cmd_cp = 1'b1; i_cmd_toc = 1'b1; i_cmd_tid = 4'd8; i_cmd_mode = 3'd6; i_cmd_valid = 1'b1;
    tick(); tick(); tick();
    drive_done(1'b0);
    n = 0;
    while (!o_cmd_ready && n < 20) begin tick(); n++; end
    n_cmp++;
    if (!o_cmd_ready || n != 2) begin
      n_bad++;
      $display("FAIL full_held: ready=%b after %0d cycles post-done, required 1 after 2", o_cmd_ready, n);
    end
    tick();
    i_cmd_valid = 1'b0;
    exp_q.push_back('{1'b1, 1'b1, 4'd8, 1'b1});
    for (int i = 0; i < 5; i++) begin
      get_obs(o, ok); e = exp_q.pop_front();
      n_cmp++;
      if (!ok || o.tid !== e.tid || o.ccc !== (e.ok & e.cp) || o.ddr !== (e.ok & ~e.cp) || o.merr !== ~e.ok) begin
        n_bad++;
        $display("FAIL full_order[%0d]: got ok=%0b ccc=%b ddr=%b merr=%b tid=%0d, required ccc=%b ddr=%b tid=%0d",
                 i, ok, o.ccc, o.ddr, o.merr, o.tid, e.ok & e.cp, e.ok & ~e.cp, e.tid);
      end
      drive_done(e.cp);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_mode_err();
    obs_t o1; obs_t o2; exp_t e; bit ok;
    push_cmd(1'b1, 1'b1, 4'd9, 3'd3);
    push_cmd(1'b0, 1'b1, 4'd10, 3'd6);
    get_obs(o1, ok); e = exp_q.pop_front();
    n_cmp++;
    if (!ok || o1.tid !== e.tid || o1.ccc !== (e.ok & e.cp) || o1.ddr !== (e.ok & ~e.cp) || o1.merr !== ~e.ok) begin
      n_bad++;
      $display("FAIL mode_drop: got ok=%0b ccc=%b ddr=%b merr=%b tid=%0d, required ccc=0 ddr=0 merr=1 tid=%0d",
               ok, o1.ccc, o1.ddr, o1.merr, o1.tid, e.tid);
    end
    get_obs(o2, ok); e = exp_q.pop_front();
    n_cmp++;
    if (!ok || o2.tid !== e.tid || o2.ccc !== (e.ok & e.cp) || o2.ddr !== (e.ok & ~e.cp) || o2.merr !== ~e.ok || o2.cyc != o1.cyc + 1) begin
      n_bad++;
      $display("FAIL mode_next: got ok=%0b ccc=%b ddr=%b merr=%b tid=%0d cyc=%0d, required ddr=1 merr=0 tid=%0d cyc=%0d",
               ok, o2.ccc, o2.ddr, o2.merr, o2.tid, o2.cyc, e.tid, o1.cyc + 1);
    end
    drive_done(1'b0);
    tick(); tick(); tick();
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e; bit ok; int n; int a;
    push_cmd(1'b0, 1'b1, 4'd11, 3'd6);
    get_obs(o, ok); e = exp_q.pop_front();
    n_cmp++;
    if (!ok || o.tid !== e.tid || o.ddr !== 1'b1) begin
      n_bad++;
      $display("FAIL to_dispatch: got ok=%0b ddr=%b tid=%0d, required ddr=1 tid=%0d", ok, o.ddr, o.tid, e.tid);
    end
    push_cmd(1'b1, 1'b1, 4'd12, 3'd6);
    n = 0;
    while (o_ddrmode_en && n < 1100) begin tick(); n++; end
    a = cyc;
    n_cmp++;
    if (o_ddrmode_en !== 1'b0 || a - o.cyc != 1000 || {o_restart_req, o_exit_req, o_sched_done} !== 3'b000) begin
      n_bad++;
      $display("FAIL to_abort_edge: enable high %0d cycles, ddr=%b pulses=%b, required 1000 cycles, ddr=0 pulses=000",
               a - o.cyc, o_ddrmode_en, {o_restart_req, o_exit_req, o_sched_done});
    end
    tick();
    n_cmp++;
    if ({o_restart_req, o_exit_req, o_sched_done} !== 3'b011 || o_timeout_err !== 1'b1) begin
      n_bad++;
      $display("FAIL to_exit_pulse: got rs/ex/dn=%b timeout_err=%b, required 011 and 1", {o_restart_req, o_exit_req, o_sched_done}, o_timeout_err);
    end
    exp_q.delete();
    repeat (10) tick();
    n_cmp++;
    if (obs_q.size() != 0 || o_timeout_err !== 1'b1 || o_ccc_en !== 1'b0 || o_ddrmode_en !== 1'b0) begin
      n_bad++;
      $display("FAIL to_flushed: got %0d dispatches timeout_err=%b ccc=%b ddr=%b, required 0 dispatches err=1 enables 0",
               obs_q.size(), o_timeout_err, o_ccc_en, o_ddrmode_en);
    end
    i_sched_en = 1'b0;
    tick();
    n_cmp++;
    if (o_timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL to_err_clear: timeout_err=%b after disable, required 0", o_timeout_err);
    end
    i_sched_en = 1'b1;
    tick();
  endtask

  task automatic test_disable_midrun();
    obs_t o; exp_t e; bit ok; logic acc;
    push_cmd(1'b1, 1'b0, 4'd13, 3'd6);
    get_obs(o, ok); e = exp_q.pop_front();
    push_cmd(1'b0, 1'b1, 4'd14, 3'd6);
    push_cmd(1'b1, 1'b1, 4'd15, 3'd6);
    i_sched_en = 1'b0;
    tick();
    n_cmp++;
    if ({o_ccc_en, o_ddrmode_en, o_restart_req, o_exit_req, o_sched_done} !== 5'b0 || !ok) begin
      n_bad++;
      $display("FAIL dis_stop: got ok=%0b ccc=%b ddr=%b rs/ex/dn=%b, required all 0",
               ok, o_ccc_en, o_ddrmode_en, {o_restart_req, o_exit_req, o_sched_done});
    end
    exp_q.delete();
    i_cmd_valid = 1'b1;
    n_cmp++;
    if (o_cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL dis_ready: o_cmd_ready=%b while disabled, required 0", o_cmd_ready);
    end
    acc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      acc = acc | o_restart_req | o_exit_req | o_sched_done;
    end
    i_cmd_valid = 1'b0;
    i_sched_en = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if (acc !== 1'b0 || obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL dis_quiet: pulse seen=%b dispatches=%0d, required 0 and 0", acc, obs_q.size());
    end
  endtask

  task automatic test_reset_midrun();
    obs_t o; exp_t e; bit ok;
    push_cmd(1'b0, 1'b0, 4'd2, 3'd6);
    get_obs(o, ok); e = exp_q.pop_front();
    push_cmd(1'b1, 1'b1, 4'd3, 3'd6);
    i_sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_ccc_en, o_ddrmode_en, o_tid} !== 6'd0 || !ok) begin
      n_bad++;
      $display("FAIL rst_async: got ok=%0b ccc=%b ddr=%b tid=%0d, required 0", ok, o_ccc_en, o_ddrmode_en, o_tid);
    end
    tick();
    i_sys_rst_n = 1'b1;
    exp_q.delete();
    repeat (4) tick();
    n_cmp++;
    if (obs_q.size() != 0 || {o_restart_req, o_exit_req, o_sched_done} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_flushed: dispatches=%0d pulses=%b, required 0 and 000", obs_q.size(), {o_restart_req, o_exit_req, o_sched_done});
    end
    push_cmd(1'b1, 1'b1, 4'd4, 3'd6);
    get_obs(o, ok); e = exp_q.pop_front();
    n_cmp++;
    if (!ok || o.tid !== e.tid || o.ccc !== (e.ok & e.cp) || o.ddr !== (e.ok & ~e.cp) || o.merr !== ~e.ok) begin
      n_bad++;
      $display("FAIL rst_restart: got ok=%0b ccc=%b ddr=%b tid=%0d, required ccc=1 ddr=0 tid=%0d", ok, o.ccc, o.ddr, o.tid, e.tid);
    end
    drive_done(1'b1);
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_ccc();
    test_restart_then_exit();
    test_fifo_full();
    test_mode_err();
    test_timeout();
    test_disable_midrun();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL global_timeout: bench still running at %0t, required completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "bench time limit");
  end

endmodule
